// File: rtl/aes_stream_fsm_pkg.sv
// Shared types and constants for the AES streaming controller: FSM states,
// key modes, register indices and the HWPE control/flag structures.
package aes_package;

   localparam int AES_NB_PARAMS  = 4;
   localparam int AES_NB_EVT     = 2;

   localparam int AES_PARAM_SRC  = 0;
   localparam int AES_PARAM_NBLK = 1;
   localparam int AES_PARAM_MODE = 2;
   localparam int AES_PARAM_DST  = 3;

   localparam logic [3:0] AES_NR_128 = 4'd10;
   localparam logic [3:0] AES_NR_192 = 4'd12;
   localparam logic [3:0] AES_NR_256 = 4'd14;

   typedef enum logic [1:0] {
      AES_MODE_128  = 2'd0,
      AES_MODE_192  = 2'd1,
      AES_MODE_256  = 2'd2,
      AES_MODE_RSVD = 2'd3
   } aes_mode_t;

   typedef enum logic [2:0] {
      AES_S_IDLE,
      AES_S_STARTING,
      AES_S_BLK_START,
      AES_S_ROUNDS,
      AES_S_DRAIN,
      AES_S_FINISHED
   } aes_stream_state_t;

   typedef struct packed {
      logic [31:0] base_addr;
      logic [31:0] trans_size;
      logic [15:0] line_stride;
      logic [15:0] line_length;
      logic [15:0] feat_stride;
      logic [15:0] feat_length;
      logic [15:0] feat_roll;
      logic        loop_outer;
      logic        realign_type;
   } addressgen_ctrl_t;

   typedef struct packed {
      logic             req_start;
      addressgen_ctrl_t addressgen_ctrl;
   } stream_ctrl_t;

   typedef struct packed {
      logic ready_start;
      logic done;
   } stream_flags_t;

   typedef struct packed {
      stream_ctrl_t plaintext_source_ctrl;
      stream_ctrl_t chipertext_sink_ctrl;
   } ctrl_streamer_t;

   typedef struct packed {
      stream_flags_t plaintext_source_flags;
      stream_flags_t chipertext_sink_flags;
   } flags_streamer_t;

   typedef struct packed {
      logic       clear;
      logic       enable;
      logic       start;
      logic [3:0] nr;
   } ctrl_engine_t;

   typedef struct packed {
      logic done;
   } flags_engine_t;

   typedef struct packed {
      logic                  done;
      logic [AES_NB_EVT-1:0] evt;
   } ctrl_slave_t;

   typedef struct packed {
      logic start;
   } flags_slave_t;

   typedef struct packed {
      logic [AES_NB_PARAMS-1:0][31:0] hwpe_params;
   } ctrl_regfile_t;

   // Reserved mode 3 falls back to the AES-128 round count.
   function automatic logic [3:0] aes_mode_to_nr(input aes_mode_t mode);
      case (mode)
         AES_MODE_192: return AES_NR_192;
         AES_MODE_256: return AES_NR_256;
         default:      return AES_NR_128;
      endcase
   endfunction

endpackage

// File: rtl/aes_stream_fsm_cfg.sv
// Combinational mapping of the latched job (src/dst/nblk) onto the
// source and sink address-generator configuration.
module aes_stream_cfg
   import aes_package::*;
#(
   parameter int DATA_W  = 32,
   parameter int BLOCK_W = 128,
   parameter int NBLK_W  = 16
) (
   input  logic [31:0]       src_i,
   input  logic [31:0]       dst_i,
   input  logic [NBLK_W-1:0] nblk_i,
   output ctrl_streamer_t    cfg_o
);

   localparam int WORDS_PER_BLK = BLOCK_W / DATA_W;

   // One line per block, one feature per block; products wrap to field width.
   function automatic addressgen_ctrl_t map_stream(input logic [31:0] base,
                                                   input logic [NBLK_W-1:0] nblk);
      addressgen_ctrl_t a;
      a              = '0;
      a.base_addr    = base;
      a.trans_size   = 32'(nblk) * 32'(WORDS_PER_BLK);
      a.line_length  = 16'(WORDS_PER_BLK);
      a.line_stride  = 16'(DATA_W / 8);
      a.feat_length  = 16'(nblk);
      a.feat_stride  = 16'(BLOCK_W / 8);
      return a;
   endfunction

   always_comb begin
      cfg_o = '0;
      cfg_o.plaintext_source_ctrl.addressgen_ctrl = map_stream(src_i, nblk_i);
      cfg_o.chipertext_sink_ctrl.addressgen_ctrl  = map_stream(dst_i, nblk_i);
   end

endmodule

// File: rtl/aes_stream_fsm.sv
// Multi-block AES job controller: one engine start per block, done after the
// sink drains. Define AES_FSM_BLOCK_EVT_EN for a per-block evt[0] pulse.
module aes_stream_fsm
   import aes_package::*;
#(
   parameter int DATA_W  = 32,
   parameter int BLOCK_W = 128,
   parameter int NBLK_W  = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            clear,
   output ctrl_streamer_t  streamer_ctrl_o,
   input  flags_streamer_t streamer_flags_i,
   output ctrl_engine_t    ctrl_engine_o,
   input  flags_engine_t   flags_engine_i,
   output ctrl_slave_t     slave_ctrl_o,
   input  flags_slave_t    slave_flags_i,
   input  ctrl_regfile_t   reg_file_i
);

   aes_stream_state_t state_q, state_d;
   logic [NBLK_W-1:0] blk_cnt_q, blk_cnt_d;
   logic [NBLK_W-1:0] nblk_q, nblk_d;
   logic [3:0]        nr_q, nr_d;
   logic [31:0]       src_q, src_d;
   logic [31:0]       dst_q, dst_d;
   ctrl_streamer_t    stream_cfg;

   logic unused_inputs;
   assign unused_inputs = ^{reg_file_i.hwpe_params[AES_PARAM_NBLK],
                            reg_file_i.hwpe_params[AES_PARAM_MODE],
                            streamer_flags_i.plaintext_source_flags.done};

   aes_stream_cfg #(
      .DATA_W  (DATA_W),
      .BLOCK_W (BLOCK_W),
      .NBLK_W  (NBLK_W)
   ) u_cfg (
      .src_i  (src_q),
      .dst_i  (dst_q),
      .nblk_i (nblk_q),
      .cfg_o  (stream_cfg)
   );

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous here, so it is just the highest-priority branch
      // of the clocked block; clear aliases it. State uses non-blocking <= only.
      if (!reset_n || clear) begin
         state_q   <= AES_S_IDLE;
         blk_cnt_q <= '0;
         nblk_q    <= '0;
         nr_q      <= '0;
         src_q     <= '0;
         dst_q     <= '0;
      end else begin
         state_q   <= state_d;
         blk_cnt_q <= blk_cnt_d;
         nblk_q    <= nblk_d;
         nr_q      <= nr_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
      end
   end

`ifdef AES_FSM_BLOCK_EVT_EN
   logic blk_evt_q, blk_evt_d;

   always_ff @(posedge clk) begin
      if (!reset_n || clear) blk_evt_q <= 1'b0;
      else                   blk_evt_q <= blk_evt_d;
   end
`endif

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d   = state_q;
      blk_cnt_d = blk_cnt_q;
      nblk_d    = nblk_q;
      nr_d      = nr_q;
      src_d     = src_q;
      dst_d     = dst_q;

      ctrl_engine_o    = '0;
      ctrl_engine_o.nr = nr_q;
      streamer_ctrl_o  = stream_cfg;
      slave_ctrl_o     = '0;
`ifdef AES_FSM_BLOCK_EVT_EN
      blk_evt_d           = 1'b0;
      slave_ctrl_o.evt[0] = blk_evt_q;
`endif

      case (state_q)
         AES_S_IDLE: begin
            ctrl_engine_o.clear = 1'b1;
            ctrl_engine_o.nr    = '0;
            if (slave_flags_i.start) begin
               src_d     = reg_file_i.hwpe_params[AES_PARAM_SRC];
               dst_d     = reg_file_i.hwpe_params[AES_PARAM_DST];
               nblk_d    = reg_file_i.hwpe_params[AES_PARAM_NBLK][NBLK_W-1:0];
               nr_d      = aes_mode_to_nr(aes_mode_t'(reg_file_i.hwpe_params[AES_PARAM_MODE][1:0]));
               blk_cnt_d = '0;
               state_d   = (nblk_d == '0) ? AES_S_FINISHED : AES_S_STARTING;
            end
         end
         AES_S_STARTING: begin
            ctrl_engine_o.enable = 1'b1;
            if (streamer_flags_i.plaintext_source_flags.ready_start &&
                streamer_flags_i.chipertext_sink_flags.ready_start) begin
               streamer_ctrl_o.plaintext_source_ctrl.req_start = 1'b1;
               streamer_ctrl_o.chipertext_sink_ctrl.req_start  = 1'b1;
               state_d = AES_S_BLK_START;
            end
         end
         AES_S_BLK_START: begin
            ctrl_engine_o.enable = 1'b1;
            ctrl_engine_o.start  = 1'b1;
            state_d              = AES_S_ROUNDS;
         end
         AES_S_ROUNDS: begin
            ctrl_engine_o.enable = 1'b1;
            if (flags_engine_i.done) begin
               blk_cnt_d = blk_cnt_q + NBLK_W'(1);
`ifdef AES_FSM_BLOCK_EVT_EN
               blk_evt_d = 1'b1;
`endif
               state_d = (blk_cnt_d == nblk_q) ? AES_S_DRAIN : AES_S_BLK_START;
            end
         end
         AES_S_DRAIN: begin
            if (streamer_flags_i.chipertext_sink_flags.done) state_d = AES_S_FINISHED;
         end
         AES_S_FINISHED: begin
            slave_ctrl_o.done = 1'b1;
            state_d           = AES_S_IDLE;
         end
         default: state_d = AES_S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_aes_stream_fsm.sv
// Randomized scoreboard bench for aes_stream_fsm: job records are queued at
// start and checked by an independent monitor when the DUT reports activity.
module tb_aes_stream_fsm;
   import aes_package::*;

   localparam int DATA_W  = 32;
   localparam int BLOCK_W = 128;
   localparam int NBLK_W  = 16;
   localparam int WPB     = BLOCK_W / DATA_W;

   logic            clk;
   logic            reset_n;
   logic            clear;
   ctrl_streamer_t  streamer_ctrl;
   flags_streamer_t streamer_flags;
   ctrl_engine_t    ctrl_engine;
   flags_engine_t   flags_engine;
   ctrl_slave_t     slave_ctrl;
   flags_slave_t    slave_flags;
   ctrl_regfile_t   reg_file;

   logic ready, start_r, spur, eng_done_m, sink_done_m;
   int   cur_l, cur_d, cur_nblk;
   int   cyc;
   int   checks, errors;

   typedef struct {
      int          nblk;
      logic [3:0]  nr;
      logic [31:0] src;
      logic [31:0] dst;
      int          t_done;
   } job_t;
   job_t exp_q[$];

   aes_stream_fsm #(.DATA_W(DATA_W), .BLOCK_W(BLOCK_W), .NBLK_W(NBLK_W)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .clear            (clear),
      .streamer_ctrl_o  (streamer_ctrl),
      .streamer_flags_i (streamer_flags),
      .ctrl_engine_o    (ctrl_engine),
      .flags_engine_i   (flags_engine),
      .slave_ctrl_o     (slave_ctrl),
      .slave_flags_i    (slave_flags),
      .reg_file_i       (reg_file)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      streamer_flags = '0;
      streamer_flags.plaintext_source_flags.ready_start = ready;
      streamer_flags.chipertext_sink_flags.ready_start  = ready;
      streamer_flags.chipertext_sink_flags.done         = sink_done_m;
      flags_engine.done = eng_done_m | spur;
      slave_flags.start = start_r;
   end

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Round count implied by the key-mode register.
   function automatic logic [3:0] model_nr(input int mode);
      case (mode)
         1:       return 4'd12;
         2:       return 4'd14;
         default: return 4'd10;
      endcase
   endfunction

   function automatic addressgen_ctrl_t model_cfg(input logic [31:0] base, input int n);
      addressgen_ctrl_t a;
      a             = '0;
      a.base_addr   = base;
      a.trans_size  = 32'(n * WPB);
      a.line_length = 16'(WPB);
      a.line_stride = 16'(DATA_W / 8);
      a.feat_length = 16'(n);
      a.feat_stride = 16'(BLOCK_W / 8);
      return a;
   endfunction

   // Engine finishes L cycles after its start pulse; the sink drains D cycles
   // after the final block's engine done.
   initial begin
      int cnt, blocks, scnt;
      eng_done_m = 1'b0; sink_done_m = 1'b0;
      cnt = 0; blocks = 0; scnt = 0;
      forever begin
         @(negedge clk);
         eng_done_m  = 1'b0;
         sink_done_m = 1'b0;
         if (ctrl_engine.clear || !reset_n) begin
            cnt = 0; blocks = 0; scnt = 0;
         end else begin
            if (scnt > 0) begin
               scnt--;
               if (scnt == 0) sink_done_m = 1'b1;
            end
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  eng_done_m = 1'b1;
                  blocks++;
                  if (blocks == cur_nblk) scnt = cur_d;
               end
            end
            if (ctrl_engine.start) cnt = cur_l;
         end
      end
   end

   // Monitor: compares DUT activity with the head of the expectation queue.
   initial begin
      int   n_req, n_start, n_evt;
      logic prev_done;
      job_t j;
      n_req = 0; n_start = 0; n_evt = 0; prev_done = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (!reset_n) begin
            n_req = 0; n_start = 0; n_evt = 0; prev_done = 1'b0;
         end else begin
            if (ctrl_engine.clear) begin
               n_req = 0; n_start = 0; n_evt = 0;
            end
            if (streamer_ctrl.plaintext_source_ctrl.req_start ||
                streamer_ctrl.chipertext_sink_ctrl.req_start) begin
               check("req_job_pending", 160'(exp_q.size() > 0), 160'(1));
               check("req_pair", 160'({streamer_ctrl.plaintext_source_ctrl.req_start,
                                       streamer_ctrl.chipertext_sink_ctrl.req_start}), 160'(2'b11));
               check("req_ready_gate", 160'(ready), 160'(1));
               if (exp_q.size() > 0) begin
                  check("src_cfg", 160'(streamer_ctrl.plaintext_source_ctrl.addressgen_ctrl),
                        160'(model_cfg(exp_q[0].src, exp_q[0].nblk)));
                  check("sink_cfg", 160'(streamer_ctrl.chipertext_sink_ctrl.addressgen_ctrl),
                        160'(model_cfg(exp_q[0].dst, exp_q[0].nblk)));
               end
               n_req++;
            end
            if (ctrl_engine.start) begin
               check("start_job_pending", 160'(exp_q.size() > 0), 160'(1));
               if (exp_q.size() > 0) check("start_nr", 160'(ctrl_engine.nr), 160'(exp_q[0].nr));
               n_start++;
            end
            if (slave_ctrl.evt[0]) n_evt++;
            if (slave_ctrl.done) begin
               check("done_one_cycle", 160'(prev_done), 160'(0));
               check("done_job_pending", 160'(exp_q.size() > 0), 160'(1));
               check("done_evt_low", 160'(slave_ctrl.evt), 160'(0));
               if (exp_q.size() > 0) begin
                  j = exp_q.pop_front();
                  check("done_latency", 160'(cyc), 160'(j.t_done));
                  check("start_count", 160'(n_start), 160'(j.nblk));
                  check("req_count", 160'(n_req), 160'(j.nblk > 0 ? 1 : 0));
`ifdef AES_FSM_BLOCK_EVT_EN
                  check("evt_count", 160'(n_evt), 160'(j.nblk));
`else
                  check("evt_count", 160'(n_evt), 160'(0));
`endif
               end
            end
            prev_done = slave_ctrl.done;
         end
      end
   end

   task automatic wait_idle();
      int t;
      t = 0;
      while (exp_q.size() > 0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("job_timeout", 160'(exp_q.size()), 160'(0));
      if (exp_q.size() > 0) begin
         exp_q.delete();
         reset_n = 1'b0;
         repeat (2) @(negedge clk);
         reset_n = 1'b1;
      end
   endtask

   task automatic run_job(input int n, input int mode, input int r, input int l, input int d,
                          input bit restart, input bit do_spur, input bit abort);
      job_t        j;
      logic [31:0] rnd;
      int          kend;
      cur_nblk = n; cur_l = l; cur_d = d;
      rnd = $urandom;
      reg_file.hwpe_params[AES_PARAM_SRC]  = $urandom;
      reg_file.hwpe_params[AES_PARAM_DST]  = $urandom;
      reg_file.hwpe_params[AES_PARAM_NBLK] = {rnd[31:16], 16'(n)};
      reg_file.hwpe_params[AES_PARAM_MODE] = {rnd[29:0], 2'(mode)};
      j.nblk   = n;
      j.nr     = model_nr(mode);
      j.src    = reg_file.hwpe_params[AES_PARAM_SRC];
      j.dst    = reg_file.hwpe_params[AES_PARAM_DST];
      j.t_done = cyc + 1 + ((n == 0) ? 0 : (1 + r + n * (1 + l) + d));
      exp_q.push_back(j);
      start_r = 1'b1;
      if (r > 0) ready = 1'b0;
      kend = (r + 1 > 2) ? r + 1 : 2;
      for (int k = 1; k <= kend; k++) begin
         @(negedge clk);
         start_r = restart && (k == 1);
         if (k == r + 1) ready = 1'b1;
         if (k == 1) reg_file.hwpe_params = {$urandom, $urandom, $urandom, $urandom};
      end
      if (abort) begin
         repeat (3 + 2 * l - kend) @(negedge clk);
         clear = 1'b1;
         @(negedge clk);
         clear = 1'b0;
         #2;
         check("abort_engine_clear", 160'(ctrl_engine.clear), 160'(1));
         check("abort_enable_low", 160'(ctrl_engine.enable), 160'(0));
         check("abort_nr_zero", 160'(ctrl_engine.nr), 160'(0));
         check("abort_no_done", 160'(slave_ctrl.done), 160'(0));
         void'(exp_q.pop_back());
         repeat (20) @(negedge clk);
      end else begin
         wait_idle();
      end
      if (do_spur) begin
         @(negedge clk); spur = 1'b1;
         @(negedge clk); spur = 1'b0;
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog_expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc = 0; checks = 0; errors = 0;
      reset_n = 1'b0; clear = 1'b0; ready = 1'b1; start_r = 1'b0; spur = 1'b0;
      cur_l = 1; cur_d = 1; cur_nblk = 0;
      reg_file = '0;
      repeat (3) @(negedge clk);
      #2;
      check("rst_engine", 160'(ctrl_engine), 160'({1'b1, 1'b0, 1'b0, 4'd0}));
      check("rst_req", 160'({streamer_ctrl.plaintext_source_ctrl.req_start,
                              streamer_ctrl.chipertext_sink_ctrl.req_start}), 160'(0));
      check("rst_slave", 160'(slave_ctrl), 160'(0));
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      run_job(1, 0, 0, 10, 1, 1'b0, 1'b0, 1'b0);
      run_job(3, 2, 0, 7, 4, 1'b1, 1'b1, 1'b0);
      run_job(0, 1, 0, 5, 1, 1'b1, 1'b0, 1'b0);
      run_job(2, 1, 5, 3, 2, 1'b0, 1'b1, 1'b0);
      run_job(4, 3, 0, 6, 1, 1'b0, 1'b0, 1'b1);
      run_job(1, 0, 0, 4, 1, 1'b0, 1'b0, 1'b0);
      run_job(4, 0, 0, 5, 2, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         run_job($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 4),
                 $urandom_range(1, 12), $urandom_range(1, 5),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
